// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants and the layout tracker FSM state type
package vga_pkg;
  localparam int VGA_VER_RES = 480;
  localparam int VGA_HOR_RES = 640;
  typedef enum logic [1:0] {IDLE, LATCH, DIVIDE, READY} layout_state_t;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring shift-subtract divider, one quotient bit per cycle
module seq_divider #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);
  localparam int CW = $clog2(W + 1);
  logic [CW-1:0] cnt;
  logic [W-1:0] dvs;
  logic [W:0] shifted, trial;
  assign shifted = {remainder, quotient[W-1]};
  assign trial = shifted - {1'b0, dvs};
  // quotient doubles as the dividend shift register; start always restarts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      dvs <= '0;
      quotient <= '0;
      remainder <= '0;
    end else if (start) begin
      busy <= 1'b1;
      done <= 1'b0;
      cnt <= CW'(W);
      dvs <= divisor;
      quotient <= dividend;
      remainder <= '0;
    end else if (busy) begin
      remainder <= trial[W] ? shifted[W-1:0] : trial[W-1:0];
      quotient <= {quotient[W-2:0], ~trial[W]};
      cnt <= cnt - CW'(1);
      busy <= cnt != CW'(1);
      done <= cnt == CW'(1);
    end else begin
      done <= 1'b0;
    end
  end
endmodule

// File: rtl/channel_layout_tracker.sv
// channel_layout_tracker: per-frame channel height divide and per-line channel tracking
module channel_layout_tracker
  import vga_pkg::*;
#(
  parameter int MAX_CHAN_COUNT = 10,
  parameter int VER_RES = VGA_VER_RES,
  parameter int OFFSET = 0,
  parameter int CHAN_W = $clog2(MAX_CHAN_COUNT),
  parameter int ROW_W = $clog2(VER_RES)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [MAX_CHAN_COUNT-1:0] channel_enable,
  input  logic                      frame_start,
  input  logic                      row_start,
  input  logic [ROW_W-1:0]          pixel_row,
  output logic                      layout_valid,
  output logic                      is_channel,
  output logic [CHAN_W-1:0]         channel_number,
  output logic [ROW_W-1:0]          channel_height,
  output logic [ROW_W-1:0]          channel_offset,
  output logic [ROW_W-1:0]          row_in_channel
);
  localparam int CNT_W = CHAN_W + 1;
  localparam logic [ROW_W-1:0] SPAN = ROW_W'(VER_RES - OFFSET);
  localparam logic [ROW_W-1:0] FIRST = ROW_W'(OFFSET);
  localparam logic [ROW_W:0] FIRST_X = (ROW_W + 1)'(OFFSET);
  localparam logic [ROW_W:0] ONE_X = 1;
  function automatic logic [CNT_W-1:0] popcount(input logic [MAX_CHAN_COUNT-1:0] v);
    popcount = '0;
    for (int i = 0; i < MAX_CHAN_COUNT; i++) popcount = popcount + CNT_W'(v[i]);
  endfunction
  function automatic logic [CHAN_W-1:0] next_bit(input logic [MAX_CHAN_COUNT-1:0] v, input int from);
    next_bit = '0;
    for (int i = MAX_CHAN_COUNT - 1; i >= 0; i--) if (v[i] && i >= from) next_bit = CHAN_W'(i);
  endfunction
  layout_state_t state, next_state;
  logic [MAX_CHAN_COUNT-1:0] en_q;
  logic [CNT_W-1:0] chan_count, vis;
  logic ch_q, div_done, div_busy_unused;
  logic [ROW_W-1:0] div_quo, div_rem_unused;
  logic before_first, more_rows;
  assign layout_valid = state == READY;
  assign is_channel = ch_q && layout_valid;
  assign before_first = {1'b0, pixel_row} + ONE_X <= FIRST_X;
  assign more_rows = {1'b0, row_in_channel} + ONE_X < {1'b0, channel_height};
  seq_divider #(.W(ROW_W)) u_div (
    .clk(clk),
    .rst(reset),
    .start(state == LATCH),
    .dividend(SPAN),
    .divisor(ROW_W'(popcount(channel_enable))),
    .busy(div_busy_unused),
    .done(div_done),
    .quotient(div_quo),
    .remainder(div_rem_unused)
  );
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= next_state;
  end
  // frame_start restarts from any state, including mid-divide
  always_comb begin
    next_state = frame_start ? LATCH :
                 (state == LATCH) ? DIVIDE :
                 (state == DIVIDE && div_done) ? READY : state;
  end
  // per-frame layout: latched enables, channel count and resulting height
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q <= '0;
      chan_count <= '0;
      channel_height <= '0;
    end else if (state == LATCH) begin
      en_q <= channel_enable;
      chan_count <= popcount(channel_enable);
      channel_height <= '0;
    end else if (state == DIVIDE && div_done) begin
      channel_height <= (chan_count == '0) ? '0 : div_quo;
    end
  end
  // line-by-line tracking; remainder rows after the last channel stay unassigned
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_q <= 1'b0;
      vis <= '0;
      channel_number <= '0;
      channel_offset <= '0;
      row_in_channel <= '0;
    end else if (state != READY) begin
      ch_q <= 1'b0;
      vis <= '0;
    end else if (row_start) begin
      if (chan_count == '0 || before_first) begin
        ch_q <= 1'b0;
      end else if (pixel_row == FIRST) begin
        ch_q <= 1'b1;
        vis <= '0;
        channel_offset <= FIRST;
        row_in_channel <= '0;
        channel_number <= next_bit(en_q, 0);
      end else if (vis == chan_count) begin
        ch_q <= 1'b0;
      end else if (more_rows) begin
        row_in_channel <= row_in_channel + ROW_W'(1);
      end else begin
        vis <= vis + CNT_W'(1);
        ch_q <= vis + CNT_W'(1) != chan_count;
        row_in_channel <= '0;
        channel_offset <= channel_offset + channel_height;
        channel_number <= next_bit(en_q, int'(channel_number) + 1);
      end
    end
  end
endmodule

// File: tb/tb_channel_layout_tracker.sv
// tb_channel_layout_tracker: randomized frames checked against an arithmetic layout model
module tb_channel_layout_tracker;
  localparam int VR = 480;
  localparam int RW = 9;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [9:0] en = '0;
  logic fs = 1'b0;
  logic rs = 1'b0;
  logic [8:0] prow = '0;
  logic lv[2];
  logic ic[2];
  logic [3:0] cn[2];
  logic [8:0] ch[2];
  logic [8:0] co[2];
  logic [8:0] ri[2];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  channel_layout_tracker #(.MAX_CHAN_COUNT(10), .VER_RES(VR), .OFFSET(0)) u0 (
    .clk(clk), .reset(reset), .channel_enable(en), .frame_start(fs), .row_start(rs),
    .pixel_row(prow), .layout_valid(lv[0]), .is_channel(ic[0]), .channel_number(cn[0]),
    .channel_height(ch[0]), .channel_offset(co[0]), .row_in_channel(ri[0])
  );
  channel_layout_tracker #(.MAX_CHAN_COUNT(10), .VER_RES(VR), .OFFSET(32)) u1 (
    .clk(clk), .reset(reset), .channel_enable(en), .frame_start(fs), .row_start(rs),
    .pixel_row(prow), .layout_valid(lv[1]), .is_channel(ic[1]), .channel_number(cn[1]),
    .channel_height(ch[1]), .channel_offset(co[1]), .row_in_channel(ri[1])
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int offs(input int d);
    return d ? 32 : 0;
  endfunction
  task automatic model(input logic [9:0] e, input int off, input int row, output bit x,
                       output int n, output int o, output int r, output int h);
    int c, v, k;
    c = $countones(e);
    h = c ? (VR - off) / c : 0;
    x = 0; n = 0; o = 0; r = 0;
    if (c == 0 || row < off) return;
    v = (row - off) / h;
    if (v >= c) return;
    x = 1;
    o = off + v * h;
    r = (row - off) % h;
    k = 0;
    for (int i = 0; i < 10; i++) if (e[i]) begin
      if (k == v) n = i;
      k++;
    end
  endtask
  task automatic start_frame(input logic [9:0] e);
    int k;
    bit x;
    int n, o, r, h;
    en = e; fs = 1'b1;
    tick;
    fs = 1'b0;
    k = 0;
    while (!(lv[0] && lv[1]) && k < 40) begin
      tick;
      k++;
    end
    checks++;
    if (!(lv[0] && lv[1])) begin
      errors++;
      $display("FAIL valid_timeout: got %0b%0b expected 11", lv[0], lv[1]);
    end
    for (int d = 0; d < 2; d++) begin
      model(e, offs(d), 0, x, n, o, r, h);
      checks++;
      if (ch[d] !== 9'(h)) begin
        errors++;
        $display("FAIL height dut%0d en %b: got %0d expected %0d", d, e, ch[d], h);
      end
    end
  endtask
  task automatic scan_rows(input logic [9:0] e, input bit toggle, input int last);
    bit x;
    int n, o, r, h;
    for (int row = 0; row <= last; row++) begin
      prow = 9'(row); rs = 1'b1;
      if (toggle) en = 10'($urandom);
      tick;
      rs = 1'b0;
      for (int d = 0; d < 2; d++) begin
        model(e, offs(d), row, x, n, o, r, h);
        checks++;
        if (ic[d] !== x) begin
          errors++;
          $display("FAIL is_channel dut%0d row %0d: got %0b expected %0b", d, row, ic[d], x);
        end
        if (x) begin
          checks++;
          if (cn[d] !== 4'(n)) begin
            errors++;
            $display("FAIL channel_number dut%0d row %0d: got %0d expected %0d", d, row, cn[d], n);
          end
          checks++;
          if (co[d] !== 9'(o)) begin
            errors++;
            $display("FAIL channel_offset dut%0d row %0d: got %0d expected %0d", d, row, co[d], o);
          end
          checks++;
          if (ri[d] !== 9'(r)) begin
            errors++;
            $display("FAIL row_in_channel dut%0d row %0d: got %0d expected %0d", d, row, ri[d], r);
          end
        end
      end
      repeat ($urandom_range(0, 2)) tick;
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    tick;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({lv[d], ic[d], cn[d], ch[d], co[d], ri[d]} !== '0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %0h expected 0", d, {lv[d], ic[d], cn[d], ch[d], co[d], ri[d]});
      end
    end
    reset = 1'b0;
    tick;
  endtask
  task automatic test_known_layouts;
    start_frame(10'b0000100101);
    checks++;
    if (ch[0] !== 9'd160) begin
      errors++;
      $display("FAIL height_160: got %0d expected 160", ch[0]);
    end
    scan_rows(10'b0000100101, 1'b0, 479);
    start_frame(10'h3ff);
    checks++;
    if (ch[1] !== 9'd44) begin
      errors++;
      $display("FAIL height_44: got %0d expected 44", ch[1]);
    end
    scan_rows(10'h3ff, 1'b0, 479);
  endtask
  task automatic test_zero_enable;
    start_frame(10'h000);
    scan_rows(10'h000, 1'b1, 479);
  endtask
  task automatic test_divide_timing;
    logic [9:0] e1, e2;
    bit x;
    int n, o, r, h;
    e1 = 10'($urandom) | 10'h001;
    e2 = ~e1 | 10'h200;
    en = e1; fs = 1'b1;
    tick;
    fs = 1'b0;
    for (int k = 0; k <= RW + 2; k++) begin
      if (k > 0) tick;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (lv[d] !== (k == RW + 2)) begin
          errors++;
          $display("FAIL valid_latency dut%0d cycle %0d: got %0b expected %0b", d, k, lv[d], k == RW + 2);
        end
      end
    end
    en = e1; fs = 1'b1;
    tick;
    fs = 1'b0;
    for (int k = 0; k <= RW + 6; k++) begin
      if (k > 0) begin
        if (k == 4) begin
          fs = 1'b1;
          en = e2;
        end
        tick;
        fs = 1'b0;
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (lv[d] !== (k == RW + 6)) begin
          errors++;
          $display("FAIL restart_latency dut%0d cycle %0d: got %0b expected %0b", d, k, lv[d], k == RW + 6);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      model(e2, offs(d), 0, x, n, o, r, h);
      checks++;
      if (ch[d] !== 9'(h)) begin
        errors++;
        $display("FAIL restart_height dut%0d: got %0d expected %0d", d, ch[d], h);
      end
    end
    scan_rows(e2, 1'b1, 479);
  endtask
  task automatic test_reset_mid;
    logic [9:0] e;
    e = 10'($urandom) | 10'h010;
    en = e; fs = 1'b1;
    tick;
    fs = 1'b0;
    repeat (4) tick;
    reset = 1'b1;
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({lv[d], ic[d], cn[d], ch[d], co[d], ri[d]} !== '0) begin
        errors++;
        $display("FAIL reset_mid_divide dut%0d: got %0h expected 0", d, {lv[d], ic[d], cn[d], ch[d], co[d], ri[d]});
      end
    end
    tick;
    reset = 1'b0;
    repeat (20) tick;
    prow = 9'd40; rs = 1'b1;
    tick;
    rs = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (lv[d] !== 1'b0 || ic[d] !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset dut%0d: got %0b%0b expected 00", d, lv[d], ic[d]);
      end
    end
    start_frame(e);
    scan_rows(e, 1'b1, 200);
    reset = 1'b1;
    #2;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({lv[d], ic[d], cn[d], ch[d], co[d], ri[d]} !== '0) begin
        errors++;
        $display("FAIL reset_mid_frame dut%0d: got %0h expected 0", d, {lv[d], ic[d], cn[d], ch[d], co[d], ri[d]});
      end
    end
    tick;
    reset = 1'b0;
    tick;
    e = 10'($urandom) | 10'h100;
    start_frame(e);
    scan_rows(e, 1'b1, 479);
  endtask
  task automatic test_random_frames;
    logic [9:0] e;
    repeat (4) begin
      e = 10'($urandom);
      start_frame(e);
      scan_rows(e, 1'b1, 479);
    end
  endtask
  initial begin
    test_reset;
    test_known_layouts;
    test_zero_enable;
    test_divide_timing;
    test_reset_mid;
    test_random_frames;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
